// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard bus: hazard-detection inputs from the ID/EX/MEM stages and
// the write-enable / bubble controls returned to the pipeline registers.
interface hazard_ctrl_if;
  // Hazard sources
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       idex_memread;
  logic [4:0] idex_rt;
  logic       branch_taken;
  logic       mem_busy;

  // Pipeline register controls
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_flush;
  logic       exmem_write;
  logic       memwb_flush;

  // Controller side
  modport slave (
    input  id_rs, id_rt, id_uses_rt, idex_memread, idex_rt, branch_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_flush
  );

  // Pipeline side
  modport master (
    output id_rs, id_rt, id_uses_rt, idex_memread, idex_rt, branch_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_flush
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: post-reset bubble fill,
// load-use stalls, taken-branch flushes, data-memory waits with a timeout that
// halts the core, and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int INIT_CYCLES = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  hazard_ctrl_if.slave     hz,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_ERR      = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic memwb_flush;
  } ctl_t;

  localparam ctl_t CTL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                  idex_write: 1'b1, idex_flush: 1'b0, exmem_write: 1'b1,
                                  memwb_flush: 1'b0};
  localparam ctl_t CTL_INIT   = '{pc_write: 1'b0, ifid_write: 1'b1, ifid_flush: 1'b1,
                                  idex_write: 1'b1, idex_flush: 1'b1, exmem_write: 1'b1,
                                  memwb_flush: 1'b1};
  localparam ctl_t CTL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                  idex_write: 1'b0, idex_flush: 1'b0, exmem_write: 1'b0,
                                  memwb_flush: 1'b1};
  // Load-use stall and the halted/draining state share the same control set.
  localparam ctl_t CTL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                  idex_write: 1'b1, idex_flush: 1'b1, exmem_write: 1'b1,
                                  memwb_flush: 1'b0};
  localparam ctl_t CTL_BRANCH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                  idex_write: 1'b1, idex_flush: 1'b0, exmem_write: 1'b1,
                                  memwb_flush: 1'b0};

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  state_e             state_q, state_d;
  logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               mem_err_q, mem_err_d;

  ctl_t ctl;
  logic apply_rules;
  logic load_use;
  logic flush_fire;
  logic stall_inc;

  // Load in EX writing a register the ID instruction reads; r0 never hazards.
  assign load_use = hz.idex_memread && (hz.idex_rt != 5'd0) &&
                    ((hz.idex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.idex_rt == hz.id_rt)));

  // Next-state and same-cycle pipeline controls.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    ctl         = CTL_NORMAL;
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    apply_rules = 1'b0;
    flush_fire  = 1'b0;

    unique case (state_q)
      S_INIT: begin
        ctl = CTL_INIT;
        if (init_cnt_q == INIT_LAST) state_d = S_RUN;
        else                         init_cnt_d = init_cnt_q + 1'b1;
      end
      S_RUN: begin
        if (hz.mem_busy) begin
          ctl        = CTL_FREEZE;
          state_d    = S_MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else begin
          apply_rules = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (!hz.mem_busy) begin
          apply_rules = 1'b1;
          state_d     = S_RUN;
        end else begin
          ctl = CTL_FREEZE;
          if (wait_cnt_q == WAIT_MAX) begin
            state_d   = S_ERR;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      S_ERR: begin
        ctl = CTL_STALL;
      end
      default: ;
    endcase

    // Load-use stall beats a taken branch; the branch re-resolves next cycle.
    if (apply_rules) begin
      if (load_use) begin
        ctl = CTL_STALL;
      end else if (hz.branch_taken) begin
        ctl        = CTL_BRANCH;
        flush_fire = 1'b1;
      end
    end

    stall_inc = ((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && !ctl.pc_write;
  end

  // Saturating performance counters; clear wins over a same-cycle increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc  && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_fire && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State, sequencing counters, perf counters and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign hz.pc_write    = ctl.pc_write;
  assign hz.ifid_write  = ctl.ifid_write;
  assign hz.ifid_flush  = ctl.ifid_flush;
  assign hz.idex_write  = ctl.idex_write;
  assign hz.idex_flush  = ctl.idex_flush;
  assign hz.exmem_write = ctl.exmem_write;
  assign hz.memwb_flush = ctl.memwb_flush;

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign mem_err   = mem_err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (INIT_CYCLES=5, MEM_TIMEOUT=4, CNT_W=4).
// Each step drives one cycle of inputs and queues the expected controls,
// state and counters; the entry is popped and compared mid-cycle.
module tb_hazard_ctrl;

  localparam int INIT_CYCLES = 5;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  // Control vector order: pc_write, ifid_write, ifid_flush, idex_write,
  // idex_flush, exmem_write, memwb_flush.
  localparam logic [6:0] C_NORMAL = 7'b1101010;
  localparam logic [6:0] C_INIT   = 7'b0111111;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_STALL  = 7'b0001110;
  localparam logic [6:0] C_BRANCH = 7'b1111010;
  localparam logic [6:0] C_ERR    = 7'b0001110;

  localparam logic [1:0] S_INIT = 2'd0, S_RUN = 2'd1, S_MW = 2'd2, S_ERR = 2'd3;

  typedef struct {
    string            tag;
    logic [6:0]       ctl;
    logic [1:0]       st;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cnt_clear = 1'b0;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_err;
  logic [1:0]       state_o;

  hazard_ctrl_if hz ();

  hazard_ctrl #(
    .INIT_CYCLES (INIT_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hz        (hz),
    .cnt_clear (cnt_clear),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .mem_err   (mem_err),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] m_stall  = '0;
  logic [CNT_W-1:0] m_flush  = '0;

  // One cycle: drive after the edge, queue expectation, compare at negedge.
  task automatic step(input string tag, input bit rst_v,
                      input bit [4:0] rs, input bit [4:0] rt, input bit uses_rt,
                      input bit memread, input bit [4:0] ex_rt,
                      input bit br, input bit busy, input bit clr,
                      input logic [6:0] ctl, input logic [1:0] st);
    exp_t e, o;
    logic [6:0] obs_ctl;
    @(posedge clk);
    #1;
    rst             = rst_v;
    hz.id_rs        = rs;
    hz.id_rt        = rt;
    hz.id_uses_rt   = uses_rt;
    hz.idex_memread = memread;
    hz.idex_rt      = ex_rt;
    hz.branch_taken = br;
    hz.mem_busy     = busy;
    cnt_clear       = clr;
    if (!rst_v) begin
      m_stall = '0;
      m_flush = '0;
    end
    e.tag = tag; e.ctl = ctl; e.st = st; e.sc = m_stall; e.fc = m_flush;
    e.err = (st == S_ERR);
    sb.push_back(e);

    @(negedge clk);
    o = sb.pop_front();
    obs_ctl = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_write,
               hz.idex_flush, hz.exmem_write, hz.memwb_flush};
    n_checks++;
    assert (obs_ctl === o.ctl) else begin
      n_fail++;
      $error("FAIL %s ctl: observed %b expected %b", o.tag, obs_ctl, o.ctl);
    end
    n_checks++;
    assert (state_o === o.st) else begin
      n_fail++;
      $error("FAIL %s state_o: observed %0d expected %0d", o.tag, state_o, o.st);
    end
    n_checks++;
    assert (stall_cnt === o.sc) else begin
      n_fail++;
      $error("FAIL %s stall_cnt: observed %0d expected %0d", o.tag, stall_cnt, o.sc);
    end
    n_checks++;
    assert (flush_cnt === o.fc) else begin
      n_fail++;
      $error("FAIL %s flush_cnt: observed %0d expected %0d", o.tag, flush_cnt, o.fc);
    end
    n_checks++;
    assert (mem_err === o.err) else begin
      n_fail++;
      $error("FAIL %s mem_err: observed %b expected %b", o.tag, mem_err, o.err);
    end

    // Counter model: registered effect of this cycle, visible next cycle.
    if (rst_v) begin
      if (clr) begin
        m_stall = '0;
        m_flush = '0;
      end else if (st == S_RUN || st == S_MW) begin
        if (!ctl[6] && m_stall != '1) m_stall = m_stall + 1'b1;
        if (ctl[4]  && m_flush != '1) m_flush = m_flush + 1'b1;
      end
    end
  endtask

  // Idle RUN cycle with no hazards.
  task automatic idle(input string tag, input logic [1:0] st);
    step(tag, 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, C_NORMAL, st);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, hazards asserted but ignored
    step("reset", 0, 5'd3, 5'd3, 1, 1, 5'd3, 1, 1, 0, C_INIT, S_INIT);
    step("reset_hold", 0, 5'd3, 5'd3, 1, 1, 5'd3, 1, 1, 0, C_INIT, S_INIT);

    // Release: exactly INIT_CYCLES fill cycles, then RUN
    for (int i = 0; i < INIT_CYCLES; i++)
      step($sformatf("init%0d", i + 1), 1, 5'd3, 5'd3, 1, 1, 5'd3, 1, 1, 0, C_INIT, S_INIT);
    idle("run_first", S_RUN);

    // Load-use on rs
    step("lu_rs", 1, 5'd8, 5'd2, 0, 1, 5'd8, 0, 0, 0, C_STALL, S_RUN);
    idle("after_lu_rs", S_RUN);
    // r0 destination never stalls
    step("lu_r0", 1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, C_NORMAL, S_RUN);
    // rt match ignored when the ID instruction does not read rt
    step("lu_rt_unused", 1, 5'd1, 5'd5, 0, 1, 5'd5, 0, 0, 0, C_NORMAL, S_RUN);
    // Non-load producer does not stall
    step("no_load", 1, 5'd7, 5'd2, 0, 0, 5'd7, 0, 0, 0, C_NORMAL, S_RUN);

    // Load-use on rt together with a taken branch: stall wins
    step("lu_vs_br", 1, 5'd1, 5'd9, 1, 1, 5'd9, 1, 0, 0, C_STALL, S_RUN);
    step("br_retry", 1, 5'd1, 5'd9, 1, 0, 5'd0, 1, 0, 0, C_BRANCH, S_RUN);
    idle("after_br", S_RUN);

    // Three-cycle memory wait, then normal
    step("mw1", 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, C_FREEZE, S_RUN);
    step("mw2", 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, C_FREEZE, S_MW);
    step("mw3", 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, C_FREEZE, S_MW);
    idle("mw_exit", S_MW);
    idle("mw_back_run", S_RUN);

    // Branch resolved on the cycle the memory wait ends
    step("mw_br1", 1, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 0, C_FREEZE, S_RUN);
    step("mw_br_exit", 1, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0, C_BRANCH, S_MW);
    // Load-use applied on a memory-wait exit cycle
    step("mw_lu1", 1, 5'd4, 5'd2, 0, 1, 5'd4, 0, 1, 0, C_FREEZE, S_RUN);
    step("mw_lu_exit", 1, 5'd4, 5'd2, 0, 1, 5'd4, 0, 0, 0, C_STALL, S_MW);
    idle("mw_lu_run", S_RUN);

    // Counter saturation and clear
    step("clear", 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1, C_NORMAL, S_RUN);
    for (int i = 0; i < 20; i++)
      step($sformatf("sat%0d", i), 1, 5'd6, 5'd2, 0, 1, 5'd6, 0, 0, 0, C_STALL, S_RUN);
    step("br_sat_chk", 1, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0, C_BRANCH, S_RUN);
    step("clr_vs_stall", 1, 5'd6, 5'd2, 0, 1, 5'd6, 0, 0, 1, C_STALL, S_RUN);
    idle("after_clr", S_RUN);

    // Memory timeout: MEM_TIMEOUT+1 freeze cycles, then ERR
    step("to_run", 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, C_FREEZE, S_RUN);
    for (int i = 0; i < MEM_TIMEOUT; i++)
      step($sformatf("to_mw%0d", i + 1), 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, C_FREEZE, S_MW);
    step("err_busy", 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, C_ERR, S_ERR);
    step("err_hold", 1, 5'd8, 5'd2, 0, 1, 5'd8, 1, 0, 0, C_ERR, S_ERR);

    // Reset out of ERR
    step("err_reset", 0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, C_INIT, S_INIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
